mod_n_tick_timer: RTL and testbench
===================================

// Module: mod_n_tick_timer
// PURPOSE
//   Programmable countdown timer that runs downstream of the Mod-N N-bit down counter.
//   It consumes that counter's Counter output as a prescaler: each cycle in which
//   Count_In == 0 (the counter's terminal count) is one timer tick.
//   It counts down a loaded number of ticks, then flags expiry. One-shot and periodic modes.
// PARAMETERS
//   CNT_BIT  4  width of Count_In; matches the upstream counter's Bit parameter
//   TMR_BIT  8  width of Load_Val / Remaining
// PORTS
//   Clk         input   1        clock, rising edge
//   Rst         input   1        synchronous, active-high reset
//   Count_In    input   CNT_BIT  upstream down-counter value
//   Start       input   1        level sampled each cycle; starts or restarts the timer
//   Stop        input   1        aborts a running timer
//   Periodic    input   1        sampled with Start; 1 = auto-reload, 0 = one-shot
//   Load_Val    input   TMR_BIT  tick count to run; sampled with Start
//   Busy        output  1        1 while in RUN
//   Done        output  1        1 while in DONE (one-shot finished)
//   Expired     output  1        1-cycle pulse on each expiry
//   Remaining   output  TMR_BIT  ticks left
//   Expire_Cnt  output  8        expiries since reset; wraps 255 -> 0
// BEHAVIOUR
//   Reset: a cycle with Rst=1 forces the following at the next edge, overriding all other inputs.
//     - state IDLE
//     - Busy=0, Done=0, Expired=0
//     - Remaining=0, Expire_Cnt=0, internal reload register=0, mode=0
//   Reset mid-RUN behaves identically; no Expired pulse is generated.
//   tick = (Count_In == 0). This is a combinational compare, used in the same cycle.
//   No edge detection is applied. The upstream counter holds 0 for exactly one cycle per period.
//   All outputs are registered.
//   States are IDLE, RUN and DONE. Per-cycle priority: Rst > Stop > Start > tick.
//   Start accepted (Start=1, Load_Val!=0, any state):
//     - Remaining<=Load_Val, reload<=Load_Val, mode<=Periodic, Done<=0, go to RUN.
//     - A tick in the same cycle is ignored.
//     - Restarting while in RUN discards the current count; no Expired pulse.
//   Start with Load_Val==0 is ignored; state and outputs are unchanged.
//   Stop=1 in RUN: go to IDLE, Remaining<=0, Busy<=0, no Expired.
//   Stop in IDLE or DONE: no effect.
//   RUN, tick and Remaining>1: Remaining<=Remaining-1.
//   RUN, tick and Remaining==1 (expiry):
//     - Expired<=1 for exactly one cycle, Expire_Cnt<=Expire_Cnt+1 (mod 256).
//     - Periodic: Remaining<=reload, stay in RUN. The reload tick is consumed, so the period
//       is reload ticks exactly.
//     - One-shot: Remaining<=0, go to DONE, Busy<=0, Done<=1.
//   RUN with no tick: hold.
//   IDLE and DONE: Remaining holds; ticks are ignored.
//   Expired is deasserted in every cycle that is not an expiry.
//   Latency: Expired rises at the first edge after the expiring tick cycle.
//   Busy/Done update at that same edge.
// TESTING
//   1 Rst=1 for 2 cycles, Count_In=0
//     -> Busy=0, Done=0, Expired=0, Remaining=0, Expire_Cnt=0, state IDLE.
//   2 Mod-9 upstream (tick every 9 cycles). Start with Load_Val=3, Periodic=0
//     -> Remaining steps 3,2,1,0.
//     -> Expired is a single pulse one cycle after the 3rd tick following Start.
//     -> Done=1, Busy=0, Expire_Cnt=1. Further ticks leave Remaining at 0.
//   3 Periodic=1, Load_Val=2, run 7 ticks
//     -> Expired pulses after ticks 2, 4 and 6, spaced 18 cycles apart.
//     -> Remaining=1 after tick 7, Expire_Cnt=3, Busy stays 1.
//   4 Load_Val=5; Stop asserted after 2 ticks, with Start=1 in the same cycle
//     -> Stop wins: IDLE, Remaining=0, no Expired.
//     -> A later Start with Load_Val=0 leaves Busy=0.
//   5 Load_Val=4; Start again (Load_Val=6) after 3 ticks, coincident with a tick
//     -> Remaining=6 (that tick is ignored), no Expired.
//     -> Expiry happens 6 ticks later.
//   6 Periodic, Load_Val=1, 256 ticks
//     -> Expired every tick; Expire_Cnt wraps to 0.
//     -> Rst asserted mid-run -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/mod_n_tick_timer.sv
// Tick-driven countdown timer fed by a mod-N down counter (tick = Count_In==0), one-shot or periodic.
// All outputs registered: Expired, Busy and Done update at the edge following the expiring tick cycle.
module mod_n_tick_timer #(
  parameter int CNT_BIT = 4,
  parameter int TMR_BIT = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [CNT_BIT-1:0] Count_In,
  input  logic               Start,
  input  logic               Stop,
  input  logic               Periodic,
  input  logic [TMR_BIT-1:0] Load_Val,
  output logic               Busy,
  output logic               Done,
  output logic               Expired,
  output logic [TMR_BIT-1:0] Remaining,
  output logic [7:0]         Expire_Cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_BIT-1:0] rem_d;
  logic [TMR_BIT-1:0] reload_q, reload_d;
  logic               mode_q, mode_d;
  logic [7:0]         exp_cnt_d;
  logic               expired_d;
  logic               busy_d, done_d;

  logic tick;
  logic start_ok;
  logic stop_run;
  logic run_tick;
  logic last_tick;

  assign tick      = (Count_In == '0);
  assign start_ok  = Start && (Load_Val != '0);
  assign stop_run  = Stop && (state_q == RUN);
  // Stop and an accepted Start both shadow a tick arriving in the same cycle.
  assign run_tick  = (state_q == RUN) && tick && !stop_run && !start_ok;
  assign last_tick = run_tick && (Remaining == TMR_BIT'(1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      Remaining  <= '0;
      reload_q   <= '0;
      mode_q     <= 1'b0;
      Expire_Cnt <= 8'd0;
      Expired    <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      Remaining  <= rem_d;
      reload_q   <= reload_d;
      mode_q     <= mode_d;
      Expire_Cnt <= exp_cnt_d;
      Expired    <= expired_d;
      Busy       <= busy_d;
      Done       <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = Remaining;
    reload_d  = reload_q;
    mode_d    = mode_q;
    exp_cnt_d = Expire_Cnt;
    expired_d = 1'b0;
    if (stop_run) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (start_ok) begin
      state_d  = RUN;
      rem_d    = Load_Val;
      reload_d = Load_Val;
      mode_d   = Periodic;
    end else if (last_tick) begin
      expired_d = 1'b1;
      exp_cnt_d = Expire_Cnt + 8'd1;
      if (mode_q) begin
        rem_d = reload_q;
      end else begin
        rem_d   = '0;
        state_d = DONE;
      end
    end else if (run_tick && (Remaining != '0)) begin
      rem_d = Remaining - TMR_BIT'(1);
    end
  end

  // Busy/Done are registered copies of the next state so they move with Expired.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_mod_n_tick_timer.sv
// Randomized and directed bench for mod_n_tick_timer against a tick-level behavioural model.
module tb_mod_n_tick_timer;

  logic       Clk;
  logic       Rst;
  logic [3:0] Count_In;
  logic       Start;
  logic       Stop;
  logic       Periodic;
  logic [7:0] Load_Val;
  logic       Busy;
  logic       Done;
  logic       Expired;
  logic [7:0] Remaining;
  logic [7:0] Expire_Cnt;

  mod_n_tick_timer #(.CNT_BIT(4), .TMR_BIT(8)) dut (
    .Clk(Clk), .Rst(Rst), .Count_In(Count_In), .Start(Start), .Stop(Stop),
    .Periodic(Periodic), .Load_Val(Load_Val), .Busy(Busy), .Done(Done),
    .Expired(Expired), .Remaining(Remaining), .Expire_Cnt(Expire_Cnt)
  );

  always #5 Clk = ~Clk;

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int mod_n = 9;
  int up_cnt = 0;
  int pulses[$];

  // Model: "ticks left", whether a countdown is active, whether a one-shot has finished.
  bit m_run, m_fin, m_per, m_pulse;
  int m_left, m_period, m_exp;

  task automatic check(input string tag, input int obs, input int exp);
    vec++;
    if (obs != exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_apply(input bit rst, input bit start, input bit stop,
                             input bit per, input int lv, input bit tick);
    m_pulse = 0;
    if (rst) begin
      m_run = 0; m_fin = 0; m_per = 0; m_left = 0; m_period = 0; m_exp = 0;
    end else if (stop && m_run) begin
      m_run = 0; m_left = 0;
    end else if (start && lv != 0) begin
      m_run = 1; m_fin = 0; m_left = lv; m_period = lv; m_per = per;
    end else if (m_run && tick) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_pulse = 1;
        m_exp = (m_exp + 1) % 256;
        if (m_per) m_left = m_period;
        else begin m_run = 0; m_fin = 1; end
      end
    end
  endtask

  task automatic step(input bit rst, input bit start, input bit stop, input bit per, input int lv);
    Rst = rst; Start = start; Stop = stop; Periodic = per;
    Load_Val = 8'(lv);
    Count_In = 4'(up_cnt);
    model_apply(rst, start, stop, per, lv, up_cnt == 0);
    @(posedge Clk);
    #1;
    cyc++;
    up_cnt = (up_cnt == 0) ? mod_n - 1 : up_cnt - 1;
    check("busy", Busy, m_run);
    check("done", Done, m_fin);
    check("expired", Expired, m_pulse);
    check("remaining", Remaining, m_left);
    check("expire_cnt", Expire_Cnt, m_exp);
    if (Expired) pulses.push_back(cyc);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    up_cnt = 0; step(1, 0, 0, 0, 0);
    up_cnt = 0; step(1, 0, 0, 0, 0);
  endtask

  // Advance until n tick cycles have been consumed; the last step is the n-th tick.
  task automatic tick_steps(input int n);
    int k = 0;
    int g = 0;
    while (k < n && g < n * 17 + 17) begin
      if (up_cnt == 0) k++;
      idle();
      g++;
    end
    check("tick_wait", k, n);
  endtask

  task automatic align_tick();
    int g = 0;
    while (up_cnt != 0 && g < 32) begin
      idle();
      g++;
    end
    check("align", up_cnt, 0);
  endtask

  initial begin
    Clk = 0; Rst = 0; Start = 0; Stop = 0; Periodic = 0; Load_Val = 0; Count_In = 0;

    // Reset state
    do_reset();
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_expired", Expired, 0);
    check("rst_remaining", Remaining, 0);
    check("rst_cnt", Expire_Cnt, 0);

    // One-shot, 3 ticks
    do_reset();
    step(0, 1, 0, 0, 3);
    pulses.delete();
    tick_steps(3);
    check("os_pulse", Expired, 1);
    check("os_done", Done, 1);
    check("os_busy", Busy, 0);
    check("os_cnt", Expire_Cnt, 1);
    tick_steps(2);
    check("os_rem_hold", Remaining, 0);
    check("os_single", pulses.size(), 1);

    // Periodic, reload 2, 7 ticks
    do_reset();
    step(0, 1, 0, 1, 2);
    pulses.delete();
    tick_steps(7);
    check("per_npulse", pulses.size(), 3);
    if (pulses.size() == 3) begin
      for (int i = 1; i < 3; i++) check("per_spacing", pulses[i] - pulses[i-1], 18);
    end
    check("per_rem", Remaining, 1);
    check("per_cnt", Expire_Cnt, 3);
    check("per_busy", Busy, 1);

    // Stop beats a simultaneous Start; zero-load Start is ignored
    do_reset();
    step(0, 1, 0, 0, 5);
    tick_steps(2);
    pulses.delete();
    step(0, 1, 1, 0, 5);
    check("stop_busy", Busy, 0);
    check("stop_rem", Remaining, 0);
    step(0, 1, 0, 0, 0);
    check("zero_start_busy", Busy, 0);
    check("stop_nopulse", pulses.size(), 0);

    // Restart coincident with a tick
    do_reset();
    step(0, 1, 0, 0, 4);
    tick_steps(3);
    check("rs_rem1", Remaining, 1);
    align_tick();
    pulses.delete();
    step(0, 1, 0, 0, 6);
    check("rs_rem6", Remaining, 6);
    check("rs_noexp", Expired, 0);
    tick_steps(5);
    check("rs_nopulse", pulses.size(), 0);
    tick_steps(1);
    check("rs_expire", Expired, 1);
    check("rs_done", Done, 1);

    // Periodic reload 1: expiry every tick, counter wraps, reset mid-run
    do_reset();
    step(0, 1, 0, 1, 1);
    pulses.delete();
    tick_steps(256);
    check("wrap_pulses", pulses.size(), 256);
    check("wrap_cnt", Expire_Cnt, 0);
    check("wrap_rem", Remaining, 1);
    align_tick();
    step(1, 0, 0, 0, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_expired", Expired, 0);
    check("midrst_rem", Remaining, 0);

    // Random traffic with varying upstream modulus
    for (int r = 0; r < 4; r++) begin
      mod_n = $urandom_range(2, 16);
      up_cnt = $urandom_range(0, mod_n - 1);
      for (int i = 0; i < 800; i++) begin
        bit rst, st, sp, pr;
        int lv;
        rst = ($urandom_range(0, 199) == 0);
        st  = ($urandom_range(0, 9) == 0);
        sp  = ($urandom_range(0, 15) == 0);
        pr  = 1'($urandom_range(0, 1));
        lv  = $urandom_range(0, 7);
        if (sp && !m_run) st = 0;
        step(rst, st, sp, pr, lv);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
